adc_sample_sequencer: RTL
=========================

Name: adc_sample_sequencer

Overview:
- Sequences the LTC2308-style serial ADC that feeds the FIR, CIC and IIR filter bank.
- Generates periodic conversion starts and drives CONVST, SCK and SDI. Shifts in 12-bit results from SDO.
- Presents each sample with a one-cycle valid strobe that the filter bank uses as its sample enable.
- Latches the per-frame channel/mode configuration and reports which channel each returned sample belongs to.

Parameters:
- SAMPLE_DIV, 250, system clocks per sample period (200 kHz at 50 MHz).
- CONVST_CYCLES, 2, system clocks o_convst is held high.
- CONV_CYCLES, 80, system clocks waited for conversion (1.6 us).
- SCK_HALF, 2, system clocks per SCK half-period (12.5 MHz SCK).
- DATA_WIDTH, 12, result bits shifted per frame.

Ports:
- i_clk  in  1  system clock (50 MHz).
- i_reset  in  1  asynchronous, active-low reset.
- i_enable  in  1  enables sample ticks.
- i_channel  in  3  channel for next conversion.
- i_single_ended  in  1  1 = single-ended, 0 = differential.
- i_unipolar  in  1  1 = unipolar, 0 = bipolar.
- i_sdo  in  1  ADC serial data out.
- o_convst  out  1  ADC conversion start.
- o_sck  out  1  ADC serial clock, idle low.
- o_sdi  out  1  ADC config data in.
- o_data  out  DATA_WIDTH  last captured sample, MSB first on wire.
- o_channel  out  3  channel that o_data belongs to.
- o_valid  out  1  one-cycle strobe, o_data/o_channel updated.
- o_busy  out  1  frame in progress (state not IDLE).
- o_overrun  out  1  one-cycle pulse, tick arrived while busy.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - All outputs 0. State IDLE, counters 0.
  - Sets the first_frame flag. cfg_prev (channel of data in flight) = 0.
- Sample counter: counts 0..SAMPLE_DIV-1 and wraps. Tick = (count==SAMPLE_DIV-1) && i_enable. While i_enable=0 the counter is held at 0.
- States: IDLE -> CONV_START -> CONV_WAIT -> SHIFT -> DONE -> IDLE.
  - IDLE: a tick at cycle T latches cfg = {i_single_ended, i_channel[0], i_channel[2], i_channel[1], i_unipolar, 1'b0} (S/D, O/S, S1, S0, UNI, SLP) and the channel. Enters CONV_START at T+1.
  - CONV_START: o_convst=1 for CONVST_CYCLES cycles.
  - CONV_WAIT: o_convst=0 for CONV_CYCLES cycles.
  - SHIFT: lasts 2*SCK_HALF*DATA_WIDTH cycles; each SCK period is SCK_HALF cycles low, then SCK_HALF cycles high.
    - o_sdi = cfg[5] on entry; it advances to the next cfg bit on each SCK falling edge. After 6 bits, o_sdi=0.
    - i_sdo is captured into the shift register, MSB first, on the last system cycle of each SCK high phase.
  - DONE (1 cycle):
    - o_data <= shift register, o_channel <= cfg_prev, cfg_prev <= latched channel.
    - o_valid=1 unless first_frame; first_frame is then cleared.
- Latency: tick at T gives o_valid at T + CONVST_CYCLES + CONV_CYCLES + 2*SCK_HALF*DATA_WIDTH + 1 (defaults: T+131).
- Pipelined config: the ADC applies the config sent in frame N to conversion N+1. o_channel therefore reports frame N-1's channel. The first frame after reset is discarded (no o_valid).
- o_busy=1 in every state except IDLE.
- Tick while o_busy=1: the tick is dropped, o_overrun pulses for 1 cycle, and the frame in progress is unaffected.
- i_enable falling mid-frame: the current frame completes normally and no new frames start.
- Input changes: i_channel/mode changes mid-frame have no effect on the current frame.
- o_data holds its value between o_valid strobes.
- Reset mid-frame: outputs drop to 0 immediately (o_sck, o_convst low). The first frame after release is discarded.

Test Plan:
- Hold i_reset=0 then release -> all outputs 0 and o_busy=0 until the first tick at cycle 249; o_convst high at cycles 250..251.
- Defaults; SDO model returns 0xA5C twice; i_channel=5, single-ended, unipolar -> SDI bits 1,1,1,0,1,0 on the first 6 SCK rising edges; 12 SCK pulses per frame; frame 1 gives no o_valid; frame 2 gives o_data=0xA5C and o_valid exactly 131 cycles after its tick.
- Frames with channel sequence 5, 2, 7 -> o_valid for frame 2 with o_channel=5, then frame 3 with o_channel=2.
- SAMPLE_DIV=100 (frame length 131) -> o_overrun pulses on every tick that lands during a frame; no frame is corrupted; every accepted frame's o_data matches the model.
- Drop i_enable during CONV_WAIT -> that frame completes with o_valid; no further o_convst pulses.
- Assert reset during SHIFT (bit 6) -> o_sck=o_convst=o_data=0 immediately; after release the next frame is discarded and the following frame is valid.

Source files
------------

// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer: paces LTC2308-style conversions, sends the 6-bit config on SDI and shifts 12-bit results in from SDO.
module adc_sample_sequencer #(
    parameter int SAMPLE_DIV    = 250,
    parameter int CONVST_CYCLES = 2,
    parameter int CONV_CYCLES   = 80,
    parameter int SCK_HALF      = 2,
    parameter int DATA_WIDTH    = 12
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic [2:0]            i_channel,
    input  logic                  i_single_ended,
    input  logic                  i_unipolar,
    input  logic                  i_sdo,
    output logic                  o_convst,
    output logic                  o_sck,
    output logic                  o_sdi,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [2:0]            o_channel,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic                  o_overrun
);
    localparam int SW = $clog2(SAMPLE_DIV);
    localparam int WW = $clog2(CONVST_CYCLES + CONV_CYCLES + 1);
    localparam int HW = $clog2(SCK_HALF + 1);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [2:0] IDLE = 3'd0, CONV_START = 3'd1, CONV_WAIT = 3'd2, SHIFT = 3'd3, DONE = 3'd4;
    logic [2:0]            state;
    logic [SW-1:0]         smp_cnt;
    logic [WW-1:0]         wait_cnt;
    logic [HW-1:0]         half_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [5:0]            sdi_sr;
    logic [2:0]            chan;
    logic [2:0]            cfg_prev;
    logic                  first_frame;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  tick;
    logic                  half_end;
    logic                  last_cap;
    assign tick     = i_enable && smp_cnt == SW'(SAMPLE_DIV - 1);
    assign half_end = half_cnt == HW'(SCK_HALF - 1);
    assign last_cap = o_sck && half_end;
    assign o_busy   = state != IDLE;
    assign o_convst = state == CONV_START;
    assign o_sdi    = state == SHIFT && sdi_sr[5];
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= IDLE;
            smp_cnt     <= '0;
            wait_cnt    <= '0;
            half_cnt    <= '0;
            bit_cnt     <= '0;
            sdi_sr      <= '0;
            chan        <= '0;
            cfg_prev    <= '0;
            first_frame <= 1'b1;
            shreg       <= '0;
            o_sck       <= 1'b0;
            o_data      <= '0;
            o_channel   <= '0;
            o_valid     <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            smp_cnt   <= (!i_enable || tick) ? '0 : smp_cnt + SW'(1);
            o_overrun <= tick && state != IDLE;
            o_valid   <= 1'b0;
            case (state)
                IDLE: if (tick) begin
                    state    <= CONV_START;
                    wait_cnt <= '0;
                    // SDI order: S/D, O/S, S1, S0, UNI, SLP
                    sdi_sr   <= {i_single_ended, i_channel[0], i_channel[2], i_channel[1], i_unipolar, 1'b0};
                    chan     <= i_channel;
                end
                CONV_START: begin
                    state    <= wait_cnt == WW'(CONVST_CYCLES - 1) ? CONV_WAIT : CONV_START;
                    wait_cnt <= wait_cnt == WW'(CONVST_CYCLES - 1) ? '0 : wait_cnt + WW'(1);
                end
                CONV_WAIT: begin
                    state    <= wait_cnt == WW'(CONV_CYCLES - 1) ? SHIFT : CONV_WAIT;
                    wait_cnt <= wait_cnt + WW'(1);
                    half_cnt <= '0;
                    bit_cnt  <= '0;
                    o_sck    <= 1'b0;
                end
                SHIFT: begin
                    half_cnt <= half_end ? '0 : half_cnt + HW'(1);
                    o_sck    <= o_sck ^ half_end;
                    if (last_cap) begin
                        shreg   <= {shreg[DATA_WIDTH-2:0], i_sdo};
                        sdi_sr  <= {sdi_sr[4:0], 1'b0};
                        bit_cnt <= bit_cnt + BW'(1);
                        // Result is published as DONE is entered so o_data and o_valid line up.
                        if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                            state       <= DONE;
                            o_data      <= {shreg[DATA_WIDTH-2:0], i_sdo};
                            o_channel   <= cfg_prev;
                            cfg_prev    <= chan;
                            o_valid     <= !first_frame;
                            first_frame <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
